mmio_responder: RTL
===================

// Module: mmio_responder
// PURPOSE
// - Data-memory-side responder for the core's memory-mapped I/O window.
// - Decodes the core's data-bus accesses (wren/address/funct3/data) that hit the MMIO window.
// - Serves byte/half/word loads and stores against LED/RGB PWM duty registers and free-running us/ms timers.
// - Drives the board LED/RGB PWM outputs; sits beside data RAM on the same bus.
// PARAMETERS
// - CLK_FREQ_HZ  12_000_000    : clk frequency; sets timer prescalers (must be a multiple of 1_000_000).
// - BASE_ADDR    32'hFFFF_FFF0 : 16-byte window base; must be 16-byte aligned.
// PORTS
// - clk            input   1   system clock; all state updates on posedge.
// - reset          input   1   synchronous, active-high reset.
// - dmem_wren      input   1   store strobe for the current access.
// - dmem_address   input   32  byte address of the access.
// - funct3         input   3   access size/sign, RV32I load/store encoding.
// - dmem_data_in   input   32  store data, right-aligned (byte in [7:0], half in [15:0]).
// - dmem_data_out  output  32  load data, registered, extended per funct3.
// - hit            output  1   registered; 1 when the previous cycle's address was in the window.
// - led            output  1   LED PWM output, active-high.
// - red            output  1   R PWM output, active-high.
// - green          output  1   G PWM output, active-high.
// - blue           output  1   B PWM output, active-high.
// BEHAVIOUR
// - Register map (offset = address - BASE_ADDR, 0x0..0xF):
//   - 0x0 DUTY   RW : [7:0] led, [15:8] red, [23:16] green, [31:24] blue.
//   - 0x4 MICROS RO : microsecond count.
//   - 0x8 MILLIS RO : millisecond count.
//   - 0xC CTRL   RW : bit0 pwm_en; bits [31:1] read 0.
// - Reset: DUTY=0, CTRL=0, MICROS=0, MILLIS=0, all prescalers=0, pwm_cnt=0, dmem_data_out=0, hit=0, led/red/green/blue=0.
// - Loads, 1-cycle latency: dmem_data_out/hit update on the edge after the address is presented.
//   - 000 LB : sign-extend.  001 LH : sign-extend.  010 LW.  100 LBU : zero-extend.  101 LHU : zero-extend.
//   - Byte/half lanes are selected by address[1:0].
// - Stores take effect at the posedge where dmem_wren=1.
//   - 000 SB : lane address[1:0].  001 SH : lane address[1].  010 SW.
//   - Byte enables apply to DUTY and CTRL only.
// - Ignored accesses (no state change; load data 0):
//   - misaligned: half with address[0]=1, or word with address[1:0]!=0;
//   - illegal funct3: load 011/110/111, store with funct3 not in {000,001,010};
//   - any store to MICROS or MILLIS.
// - Out-of-window access: hit=0, dmem_data_out=0, no state change.
// - Read and write to the same register in one cycle: the load returns the pre-write value.
// - Timers:
//   - us_pre counts 0..CLK_FREQ_HZ/1e6-1; at terminal count MICROS++ and us_pre wraps to 0.
//   - ms_pre counts 0..999 on microsecond ticks; at terminal count MILLIS++.
//   - Both counters wrap at 2^32 (0xFFFF_FFFF -> 0) with no flag.
// - PWM:
//   - 8-bit pwm_cnt increments every clk, wrapping 255->0.
//   - Outputs are registered: out = pwm_en & (pwm_cnt < duty).
//   - duty=0 -> always 0; duty=255 -> high 255 of 256 cycles.
//   - pwm_en=0 forces all four outputs to 0 on the next edge; pwm_cnt keeps running.
// - Reset asserted mid-operation overrides any same-cycle store; all state returns to reset values on that edge.
// TESTING
// - Reset, then SW 0x8040_FF10 to 0x0 and SW 1 to 0xC -> LW 0x0 returns 0x8040_FF10 next cycle; over 256 cycles led high 16, red 255, green 64, blue 128.
// - SB 0x7F to offset 0x2, then LB offset 0x3 -> DUTY=0x807F_FF10; LB returns 0xFFFF_FF80; LBU returns 0x0000_0080.
// - SH to offset 0x1 (misaligned), and SW to offset 0x4 -> DUTY and MICROS unchanged; LW offset 0x1 returns 0; hit=1.
// - CLK_FREQ_HZ=2_000_000: after 2_000_000 cycles from reset -> MICROS=1_000_000, MILLIS=1000.
// - Force MICROS=0xFFFF_FFFF, run one us tick -> MICROS=0; access to BASE_ADDR-4 -> hit=0, data 0, no state change.
// - Reset asserted in the same cycle as SW 0xFF to 0x0 -> DUTY=0 afterwards, all outputs 0.

Source files
------------

// File: rtl/mmio_responder_if.sv
// Data-bus signals between the core (master) and the MMIO responder (slave).
// One load/store access per cycle; load data and hit return one cycle later.
interface mmio_responder_if;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [2:0]  funct3;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic        hit;

  modport master (
    output dmem_wren, dmem_address, funct3, dmem_data_in,
    input  dmem_data_out, hit
  );

  modport slave (
    input  dmem_wren, dmem_address, funct3, dmem_data_in,
    output dmem_data_out, hit
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO window responder: PWM duty/control registers plus free-running us/ms timers,
// serving RV32I byte/half/word loads and stores with one cycle of load latency.
module mmio_responder #(
  parameter int unsigned CLK_FREQ_HZ = 12_000_000,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFF0
) (
  input  logic             clk,
  input  logic             reset,
  mmio_responder_if.slave  bus,
  output logic             led,
  output logic             red,
  output logic             green,
  output logic             blue
);

  localparam int unsigned    UsDiv  = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned    UsW    = (UsDiv > 1) ? $clog2(UsDiv) : 1;
  localparam logic [UsW-1:0] UsLast = UsW'(UsDiv - 1);

  typedef enum logic [1:0] {RegDuty, RegMicros, RegMillis, RegCtrl} reg_e;

  logic [UsW-1:0] us_pre_q, us_pre_d;
  logic [9:0]     ms_pre_q, ms_pre_d;
  logic [31:0]    micros_q, micros_d;
  logic [31:0]    millis_q, millis_d;
  logic [31:0]    duty_q, duty_d;
  logic           pwm_en_q, pwm_en_d;
  logic [7:0]     pwm_cnt_q;
  logic [3:0]     pwm_q, pwm_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           hit_q;

  logic        in_win, misaligned, ld_ok, st_ok, us_tick, ms_tick;
  reg_e        sel;
  logic [1:0]  lane;
  logic [31:0] rword, wd;
  logic [3:0]  be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Access decode
  always_comb begin
    in_win     = bus.dmem_address[31:4] == BASE_ADDR[31:4];
    sel        = reg_e'(bus.dmem_address[3:2]);
    lane       = bus.dmem_address[1:0];
    misaligned = (bus.funct3[1:0] == 2'b01 && lane[0]) ||
                 (bus.funct3[1:0] == 2'b10 && lane != 2'b00);
    ld_ok      = in_win && !misaligned &&
                 (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    st_ok      = in_win && bus.dmem_wren && !misaligned &&
                 (bus.funct3 inside {3'b000, 3'b001, 3'b010}) &&
                 (sel == RegDuty || sel == RegCtrl);
  end

  // Load path: reads always see the pre-store register contents
  always_comb begin
    unique case (sel)
      RegDuty:   rword = duty_q;
      RegMicros: rword = micros_q;
      RegMillis: rword = millis_q;
      RegCtrl:   rword = {31'b0, pwm_en_q};
      default:   rword = '0;
    endcase
    ld_byte = 8'(rword >> {lane, 3'b000});
    ld_half = 16'(rword >> {lane[1], 4'b0000});
    rdata_d = '0;
    if (ld_ok) begin
      case (bus.funct3)
        3'b000:  rdata_d = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  rdata_d = {{16{ld_half[15]}}, ld_half};
        3'b010:  rdata_d = rword;
        3'b100:  rdata_d = {24'b0, ld_byte};
        3'b101:  rdata_d = {16'b0, ld_half};
        default: rdata_d = '0;
      endcase
    end
  end

  // Store path: replicate data across lanes and mask with byte enables
  always_comb begin
    be = 4'b0000;
    wd = bus.dmem_data_in;
    case (bus.funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{bus.dmem_data_in[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << {lane[1], 1'b0};
        wd = {2{bus.dmem_data_in[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    duty_d   = duty_q;
    pwm_en_d = pwm_en_q;
    for (int i = 0; i < 4; i++) begin
      if (st_ok && sel == RegDuty && be[i]) duty_d[8*i +: 8] = wd[8*i +: 8];
    end
    if (st_ok && sel == RegCtrl && be[0]) pwm_en_d = wd[0];
  end

  // Timers and PWM compare
  always_comb begin
    us_tick  = us_pre_q == UsLast;
    us_pre_d = us_tick ? '0 : us_pre_q + 1'b1;
    micros_d = micros_q + {31'b0, us_tick};
    ms_tick  = us_tick && ms_pre_q == 10'd999;
    ms_pre_d = ms_pre_q;
    if (us_tick) ms_pre_d = ms_tick ? 10'd0 : ms_pre_q + 10'd1;
    millis_d = millis_q + {31'b0, ms_tick};
    for (int i = 0; i < 4; i++) begin
      pwm_d[i] = pwm_en_q && (pwm_cnt_q < duty_q[8*i +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      us_pre_q  <= '0;
      ms_pre_q  <= '0;
      micros_q  <= '0;
      millis_q  <= '0;
      duty_q    <= '0;
      pwm_en_q  <= 1'b0;
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
    end else begin
      us_pre_q  <= us_pre_d;
      ms_pre_q  <= ms_pre_d;
      micros_q  <= micros_d;
      millis_q  <= millis_d;
      duty_q    <= duty_d;
      pwm_en_q  <= pwm_en_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_q     <= pwm_d;
      rdata_q   <= rdata_d;
      hit_q     <= in_win;
    end
  end

  assign bus.dmem_data_out = rdata_q;
  assign bus.hit           = hit_q;
  assign led               = pwm_q[0];
  assign red               = pwm_q[1];
  assign green             = pwm_q[2];
  assign blue              = pwm_q[3];

endmodule
